regfile_mp: RTL

Multi-port, parametrised integer register file for the NPC core; the next generation of the single-write, two-read 64-bit file. It provides NRD combinational read ports, NWR write ports with fixed priority, and a per-register busy scoreboard. The issue stage sets a register busy and writeback clears it, so issue can detect read-after-write hazards without a separate unit. It sits between decode/issue (reads, busy marking) and writeback (writes).

---
 rtl/npc_regfile_pkg.sv | 41 ++++
 rtl/regfile_scoreboard.sv | 59 +++++
 rtl/regfile_mp.sv | 112 +++++++++++
 3 files changed

// File: rtl/npc_regfile_pkg.sv
// ============================================================================
// Package     : npc_regfile_pkg
// Description : Shared constants, address type and write-port priority select
//               for the multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package npc_regfile_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;
    localparam int NWR_DEF  = 2;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0] addr_t;

    // Upper bounds for the packed arguments of wr_port_sel; callers zero-extend.
    localparam int MAX_WR = 8;
    localparam int MAX_AW = 16;

    // Highest-indexed enabled port writing address a, or -1 when none.
    function automatic int wr_port_sel(
        input logic [MAX_WR-1:0]        en,
        input logic [MAX_WR*MAX_AW-1:0] addr,
        input logic [MAX_AW-1:0]        a
    );
        int sel;
        sel = -1;
        for (int p = 0; p < MAX_WR; p++) begin
            if (en[p] && (addr[p*MAX_AW +: MAX_AW] == a)) begin
                sel = p;
            end
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy bits; set at issue, cleared at writeback,
//               cleared wholesale on flush. Register 0 is never busy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import npc_regfile_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NWR  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NWR-1:0]             wr_en,
    input  logic [NWR*$clog2(NREG)-1:0] wr_addr,
    input  logic                       iss_en,
    input  logic [$clog2(NREG)-1:0]    iss_addr,
    input  logic                       flush,
    output logic [NREG-1:0]            busy_vec
);

    localparam int AW = $clog2(NREG);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Later assignments override earlier ones: writeback, then issue, then flush.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p]) begin
                busy_d[wr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module      : regfile_mp
// Description : Multi-port register file with priority write ports and busy
//               scoreboard. Define REGFILE_BYPASS_EN for write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
    import npc_regfile_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NRD*$clog2(NREG)-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]         rd_data,
    output logic [NRD-1:0]              rd_busy,
    input  logic [NWR-1:0]              wr_en,
    input  logic [NWR*$clog2(NREG)-1:0] wr_addr,
    input  logic [NWR*XLEN-1:0]         wr_data,
    input  logic                        iss_en,
    input  logic [$clog2(NREG)-1:0]     iss_addr,
    input  logic                        flush,
    output logic [NREG-1:0]             busy_vec
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]            regs_q [NREG];
    logic [MAX_WR-1:0]          w_en_ext;
    logic [MAX_WR*MAX_AW-1:0]   w_addr_ext;
    int                         w_sel [NREG];

    always_comb begin
        w_en_ext   = '0;
        w_addr_ext = '0;
        for (int p = 0; p < NWR; p++) begin
            w_en_ext[p]                     = wr_en[p];
            w_addr_ext[p*MAX_AW +: MAX_AW]  = MAX_AW'(wr_addr[p*AW +: AW]);
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_sel[r] = wr_port_sel(w_en_ext, w_addr_ext, MAX_AW'(r));
        end
    end

    // Register 0 is only ever written by reset, so it reads as constant zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (w_sel[r] >= 0) begin
                    regs_q[r] <= wr_data[w_sel[r]*XLEN +: XLEN];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_ra = rd_addr[i*AW +: AW];

`ifdef REGFILE_BYPASS_EN
        int w_bsel;

        always_comb begin
            w_bsel = wr_port_sel(w_en_ext, w_addr_ext, MAX_AW'(w_ra));
            w_data = regs_q[w_ra];
            w_busy = busy_vec[w_ra];
            if ((w_ra != '0) && (w_bsel >= 0)) begin
                w_data = wr_data[w_bsel*XLEN +: XLEN];
                w_busy = 1'b0;
            end
        end
`else
        assign w_data = regs_q[w_ra];
        assign w_busy = busy_vec[w_ra];
`endif

        assign rd_data[i*XLEN +: XLEN] = w_data;
        assign rd_busy[i]              = w_busy;
    end

endmodule

`default_nettype wire
